// File: rtl/hmm_obs_generator_pkg.sv
// Shared constants, FSM encoding and LFSR helper for the HMM observation generator.
package hmm_obs_generator_pkg;

  localparam int I  = 3;
  localparam int K  = 3;
  localparam int N  = 5;
  localparam int P  = 16;

  localparam int IW = $clog2(I);
  localparam int KW = $clog2(K);
  localparam int LW = $clog2(N + 1);

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SAMP_S,
    SAMP_O,
    EMIT,
    DONE
  } fsm_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hmm_obs_generator_cdf_sampler.sv
// Combinational inverse-CDF lookup: smallest index whose threshold covers the draw.
module hmm_cdf_sampler
  import hmm_obs_generator_pkg::*;
#(
  parameter  int ENTRIES = 3,
  parameter  int DATA_W  = P,
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] cdf_i [ENTRIES],
  output logic [IDX_W-1:0]  idx_o
);

  // Scanning downward lets the lowest matching index win; no match keeps the last entry.
  always_comb begin
    idx_o = IDX_W'(ENTRIES - 1);
    for (int j = ENTRIES - 1; j >= 0; j--) begin
      if (r_i <= cdf_i[j]) begin
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/hmm_obs_generator.sv
// Draws a hidden-state path and emitted symbols from an HMM using LFSR randomness,
// streaming symbols with valid/ready and exposing the true path for decoder checking.
module hmm_obs_generator
  import hmm_obs_generator_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [LW-1:0] req_len,
  input  logic [15:0]   seed,
  input  logic [P-1:0]  cdfC [I],
  input  logic [P-1:0]  cdfA [I][I],
  input  logic [P-1:0]  cdfB [I][K],
  input  logic          obs_ready,
  output logic          start,
  output logic [LW-1:0] vit_length,
  output logic [KW-1:0] obs_out,
  output logic          obs_valid,
  output logic [IW-1:0] state_seq [N],
  output logic          busy,
  output logic          done
);

  fsm_e          state_q, state_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          obs_valid_q, obs_valid_d;
  logic [KW-1:0] obs_q, obs_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] t_q, t_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [IW-1:0] s_q, s_d;
  logic [IW-1:0] seq_q [N];
  logic [IW-1:0] seq_d [N];

  logic [P-1:0]  st_row [I];
  logic [P-1:0]  ob_row [K];
  logic [IW-1:0] st_idx;
  logic [KW-1:0] ob_idx;
  logic [P-1:0]  draw;
  logic [LW-1:0] len_clamped;

  assign draw        = lfsr_q[P-1:0];
  assign len_clamped = (req_len > LW'(N)) ? LW'(N) : req_len;

  // The first step draws from the initial distribution, later steps from the previous state's row.
  always_comb begin
    for (int j = 0; j < I; j++) begin
      st_row[j] = (t_q == '0) ? cdfC[j] : cdfA[s_q][j];
    end
    for (int j = 0; j < K; j++) begin
      ob_row[j] = cdfB[s_q][j];
    end
  end

  hmm_cdf_sampler #(
    .ENTRIES (I),
    .DATA_W  (P)
  ) u_state_sampler (
    .r_i   (draw),
    .cdf_i (st_row),
    .idx_o (st_idx)
  );

  hmm_cdf_sampler #(
    .ENTRIES (K),
    .DATA_W  (P)
  ) u_symbol_sampler (
    .r_i   (draw),
    .cdf_i (ob_row),
    .idx_o (ob_idx)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    obs_valid_d = obs_valid_q;
    obs_d       = obs_q;
    len_d       = len_q;
    t_d         = t_q;
    lfsr_d      = lfsr_q;
    s_d         = s_q;
    seq_d       = seq_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          len_d  = len_clamped;
          t_d    = '0;
          lfsr_d = (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
          for (int i = 0; i < N; i++) begin
            seq_d[i] = '0;
          end
          // A zero-length request completes without ever notifying the decoder.
          if (len_clamped == '0) begin
            state_d = DONE;
          end else begin
            state_d = START;
            start_d = 1'b1;
          end
        end
      end
      START: begin
        state_d = SAMP_S;
      end
      SAMP_S: begin
        s_d        = st_idx;
        seq_d[t_q] = st_idx;
        lfsr_d     = lfsr_next(lfsr_q);
        state_d    = SAMP_O;
      end
      SAMP_O: begin
        obs_d       = ob_idx;
        obs_valid_d = 1'b1;
        lfsr_d      = lfsr_next(lfsr_q);
        state_d     = EMIT;
      end
      EMIT: begin
        if (obs_valid_q && obs_ready) begin
          obs_valid_d = 1'b0;
          if ((t_q + LW'(1)) < len_q) begin
            t_d     = t_q + LW'(1);
            state_d = SAMP_S;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      obs_valid_q <= 1'b0;
      obs_q       <= '0;
      len_q       <= '0;
      t_q         <= '0;
      lfsr_q      <= LFSR_SEED_DEFAULT;
      s_q         <= '0;
      for (int i = 0; i < N; i++) begin
        seq_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      obs_valid_q <= obs_valid_d;
      obs_q       <= obs_d;
      len_q       <= len_d;
      t_q         <= t_d;
      lfsr_q      <= lfsr_d;
      s_q         <= s_d;
      for (int i = 0; i < N; i++) begin
        seq_q[i] <= seq_d[i];
      end
    end
  end

  assign start      = start_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign obs_valid  = obs_valid_q;
  assign obs_out    = obs_q;
  assign vit_length = len_q;
  assign state_seq  = seq_q;

endmodule

// File: doc/hmm_obs_generator.md
HMM_OBS_GENERATOR -- requirements
Module: hmm_obs_generator

Interface
REQ-001 Parameters SHALL be: I=3 (hidden states); K=3 (observation symbols); N=5 (max sequence length); P=16 (CDF/random width).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 go  input  1  run request, sampled only in IDLE.
REQ-005 req_len  input  $clog2(N+1)  requested sequence length.
REQ-006 seed  input  16  LFSR seed, loaded on accepted go.
REQ-007 cdfC/cdfA/cdfB  input  P each, arrays [I], [I][I], [I][K]  unsigned cumulative thresholds (initial, transition, emission); held stable while busy.
REQ-008 obs_ready  input  1  downstream accepts obs_out.
REQ-009 start  output  1  one-cycle run-start pulse to the Viterbi decoder.
REQ-010 vit_length  output  $clog2(N+1)  effective length; valid from start until next go.
REQ-011 obs_out  output  $clog2(K)  emitted symbol.
REQ-012 obs_valid  output  1  obs_out valid.
REQ-013 state_seq  output  $clog2(I) x [0:N-1]  true hidden path (golden reference).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, START, SAMP_S, SAMP_O, EMIT, DONE; all outputs registered.
REQ-017 IDLE: go=1 with req_len 1..N -> START; req_len>N -> clamped to N; req_len=0 -> DONE, no start pulse.
REQ-018 START: start=1, vit_length latched, t=0, LFSR=seed (seed 0 -> 16'hACE1); next SAMP_S.
REQ-019 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, one step per SAMP_S/SAMP_O cycle; draw r = LFSR[P-1:0] before the step.
REQ-020 Sampling: index = smallest j with r <= cdf[j]; no match -> last index (I-1 or K-1).
REQ-021 SAMP_S: state s_t from cdfC (t=0) or cdfA[s_(t-1)]; state_seq[t]=s_t; next SAMP_O.
REQ-022 SAMP_O: obs_out from cdfB[s_t]; next EMIT with obs_valid=1.
REQ-023 EMIT: obs_out/obs_valid held stable until obs_valid && obs_ready; on transfer, obs_valid drops; t<len-1 -> t++, SAMP_S; else DONE.
REQ-024 Steady throughput SHALL be one symbol per 3 cycles with obs_ready=1; first obs_valid 3 cycles after start.
REQ-025 DONE: done=1 one cycle; -> IDLE; state_seq retained until next accepted go; entries >= len are 0.
REQ-026 go while busy SHALL be ignored.

Reset
REQ-027 On rst_n low, at any time including mid-run: FSM=IDLE; start, obs_valid, done, busy, obs_out, vit_length, t, all state_seq = 0; LFSR=16'hACE1.
REQ-028 After release, no output SHALL change until an accepted go.

Structure
REQ-029 Shared package SHALL hold I, K, N, P, the FSM enum, LFSR default seed and tap constant.
REQ-030 One sub-module hmm_cdf_sampler (combinational threshold search, parameterised on entry count) SHALL be instantiated for state and symbol draws.

Verification
REQ-031 Reset: rst_n low 2 cycles -> all outputs 0, busy=0.
REQ-032 Deterministic chain: cdfC={0,0,FFFF}; cdfA[i] forces (i+1)%3; cdfB[i] forces symbol i; req_len=5, obs_ready=1 -> one start pulse, vit_length=5, obs 2,0,1,2,0, state_seq {2,0,1,2,0}, done 17 cycles after start.
REQ-033 Backpressure: same setup, obs_ready=0 for 3 cycles during symbol 1 -> obs_out=0 held, no symbol lost or duplicated, done delayed 3 cycles.
REQ-034 Length edges: req_len=0 -> done next cycle, no start; req_len=7 -> vit_length=5, 5 symbols.
REQ-035 Randomness: two runs seed=16'h1234 -> identical obs/state_seq; seed 0 equals seed 16'hACE1 run.
REQ-036 Reset mid-EMIT with obs_valid=1 -> all outputs 0 immediately; next go runs cleanly.
